// File: rtl/pipe_regfile_if.sv
// Bus bundle for pipe_regfile: two write ports, two combinational read ports,
// clear request and busy status.
interface pipe_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) ();
  logic            clr_req;
  logic            we0;
  logic            we1;
  logic [AW-1:0]   waddr0;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata0;
  logic [XLEN-1:0] wdata1;
  logic [AW-1:0]   raddr0;
  logic [AW-1:0]   raddr1;
  logic [XLEN-1:0] rdata0;
  logic [XLEN-1:0] rdata1;
  logic            busy;

  modport master (
    output clr_req, we0, we1, waddr0, waddr1, wdata0, wdata1, raddr0, raddr1,
    input  rdata0, rdata1, busy
  );

  modport slave (
    input  clr_req, we0, we1, waddr0, waddr1, wdata0, wdata1, raddr0, raddr1,
    output rdata0, rdata1, busy
  );
endinterface

// File: rtl/pipe_regfile.sv
// 2-write / 2-read register file with hardwired-zero x0, optional write-to-read
// forwarding, and a one-entry-per-cycle clear sequence after reset or clr_req.
module pipe_regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           rst,
  pipe_regfile_if.slave bus
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic            last;
  logic            busy;
  logic            wr0;
  logic            wr1;
  logic [XLEN-1:0] regs [NREG];

  assign last = (cnt == AW'(NREG - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (last)        state_nxt = READY;
      READY:   if (bus.clr_req) state_nxt = CLEAR;
      default:                  state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
    wr1  = !busy && bus.we1 && (bus.waddr1 != '0);
    // Port 1 owns a shared address, so port 0 is suppressed rather than overwritten.
    wr0  = !busy && bus.we0 && (bus.waddr0 != '0)
           && !(bus.we1 && (bus.waddr1 == bus.waddr0));
  end

  // Counter idles at 0 in READY, so any entry into CLEAR starts from entry 0.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + AW'(1);
    else                    cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[cnt] <= '0;
      end else begin
        if (wr0) regs[bus.waddr0] <= bus.wdata0;
        if (wr1) regs[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = regs[a];
    if (BYPASS != 0) begin
      if (bus.we0 && (bus.waddr0 == a)) v = bus.wdata0;
      if (bus.we1 && (bus.waddr1 == a)) v = bus.wdata1;
    end
    if (busy || (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    bus.busy   = busy;
    bus.rdata0 = rd(bus.raddr0);
    bus.rdata1 = rd(bus.raddr1);
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// Scoreboard bench for pipe_regfile: BYPASS=1 and BYPASS=0 instances share stimulus
// and are checked against an array-based model of the register file.
module tb_pipe_regfile;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_regfile_if #(.XLEN(XLEN), .AW(AW)) ifb ();
  pipe_regfile_if #(.XLEN(XLEN), .AW(AW)) ifn ();

  pipe_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));
  pipe_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .bus(ifn.slave));

  typedef struct {
    logic        busy;
    logic [31:0] b0, b1, n0, n1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] mem [NREG];
  int          clear_left;

  logic          s_rst, s_clr, s_we0, s_we1;
  logic [AW-1:0] s_wa0, s_wa1, s_ra0, s_ra1;
  logic [31:0]   s_wd0, s_wd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("busy_b",   {31'b0, ifb.busy}, {31'b0, e.busy});
      chk("busy_n",   {31'b0, ifn.busy}, {31'b0, e.busy});
      chk("rdata0_b", ifb.rdata0, e.b0);
      chk("rdata1_b", ifb.rdata1, e.b1);
      chk("rdata0_n", ifn.rdata0, e.n0);
      chk("rdata1_n", ifn.rdata1, e.n1);
    end
  end

  function automatic logic [31:0] exp_read(input logic [AW-1:0] a, input bit bp);
    if (clear_left > 0 || a == 0) return 32'h0;
    if (bp && s_we1 && s_wa1 == a) return s_wd1;
    if (bp && s_we0 && s_wa0 == a) return s_wd0;
    return mem[a];
  endfunction

  task automatic idle();
    s_rst = 1'b0; s_clr = 1'b0; s_we0 = 1'b0; s_we1 = 1'b0;
    s_wa0 = '0; s_wa1 = '0; s_wd0 = '0; s_wd1 = '0; s_ra0 = '0; s_ra1 = '0;
  endtask

  task automatic drive();
    rst = s_rst;
    ifb.clr_req = s_clr; ifn.clr_req = s_clr;
    ifb.we0 = s_we0;     ifn.we0 = s_we0;
    ifb.we1 = s_we1;     ifn.we1 = s_we1;
    ifb.waddr0 = s_wa0;  ifn.waddr0 = s_wa0;
    ifb.waddr1 = s_wa1;  ifn.waddr1 = s_wa1;
    ifb.wdata0 = s_wd0;  ifn.wdata0 = s_wd0;
    ifb.wdata1 = s_wd1;  ifn.wdata1 = s_wd1;
    ifb.raddr0 = s_ra0;  ifn.raddr0 = s_ra0;
    ifb.raddr1 = s_ra1;  ifn.raddr1 = s_ra1;
  endtask

  // Drive this cycle's inputs, queue the expected outputs, then advance the model past the edge.
  task automatic apply();
    exp_t e;
    drive();
    e.busy = (clear_left > 0);
    e.b0 = exp_read(s_ra0, 1'b1);
    e.b1 = exp_read(s_ra1, 1'b1);
    e.n0 = exp_read(s_ra0, 1'b0);
    e.n1 = exp_read(s_ra1, 1'b0);
    sb.push_back(e);
    if (s_rst) begin
      clear_left = NREG;
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) foreach (mem[i]) mem[i] = 32'h0;
    end else begin
      if (s_we0 && s_wa0 != 0) mem[s_wa0] = s_wd0;
      if (s_we1 && s_wa1 != 0) mem[s_wa1] = s_wd1;
      if (s_clr) clear_left = NREG;
    end
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    apply();
    advance();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ifb.busy === 1'b1 && n < 200) begin
      idle();
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    foreach (mem[i]) mem[i] = 32'h0;
    clear_left = NREG;
    idle();
    s_rst = 1'b1;
    drive();
    advance();

    // Two reset cycles, then the full clear
    s_rst = 1'b1;
    step();
    idle();
    wait_ready(n);
    chk("busy_len_reset", n, 32);
    for (int i = 0; i < NREG; i++) begin
      idle(); s_ra0 = AW'(i); s_ra1 = AW'(NREG - 1 - i);
      step();
    end

    // x5 write, read back on both ports; x0 write discarded
    idle(); s_we0 = 1'b1; s_wa0 = 5; s_wd0 = 32'hDEADBEEF; step();
    idle(); s_ra0 = 5; s_ra1 = 5; apply();
    chk("x5_r0", ifb.rdata0, 32'hDEADBEEF);
    chk("x5_r1", ifn.rdata1, 32'hDEADBEEF);
    advance();
    idle(); s_we0 = 1'b1; s_wa0 = 0; s_wd0 = 32'h1234; s_ra0 = 0; apply();
    chk("x0_bypass", ifb.rdata0, 32'h0);
    advance();
    idle(); s_ra0 = 0; apply();
    chk("x0_read", ifn.rdata0, 32'h0);
    advance();

    // Same-address write conflict on x7
    idle(); s_we0 = 1'b1; s_wa0 = 7; s_wd0 = 32'hAAAA0000;
    s_we1 = 1'b1; s_wa1 = 7; s_wd1 = 32'h5555FFFF; s_ra0 = 7; apply();
    chk("conflict_bypass", ifb.rdata0, 32'h5555FFFF);
    advance();
    idle(); s_ra0 = 7; s_ra1 = 7; apply();
    chk("conflict_b", ifb.rdata1, 32'h5555FFFF);
    chk("conflict_n", ifn.rdata0, 32'h5555FFFF);
    advance();

    // Forwarding off vs on for x3
    idle(); s_we1 = 1'b1; s_wa1 = 3; s_wd1 = 32'h11; step();
    idle(); s_we0 = 1'b1; s_wa0 = 3; s_wd0 = 32'h22; s_ra0 = 3; apply();
    chk("nobypass_old", ifn.rdata0, 32'h11);
    chk("bypass_new", ifb.rdata0, 32'h22);
    advance();
    idle(); s_ra0 = 3; apply();
    chk("nobypass_next", ifn.rdata0, 32'h22);
    advance();

    // Clear request with write attempted while busy
    idle(); s_we0 = 1'b1; s_wa0 = 9; s_wd0 = 32'hFF; step();
    idle(); s_clr = 1'b1; s_ra0 = 9; step();
    idle(); s_we0 = 1'b1; s_wa0 = 9; s_wd0 = 32'h77; s_ra0 = 9; s_clr = 1'b1; apply();
    chk("busy_read_zero", ifb.rdata0, 32'h0);
    advance();
    wait_ready(n);
    chk("busy_len_clr", n, 31);
    idle(); s_ra0 = 9; s_ra1 = 9; apply();
    chk("x9_cleared", ifb.rdata0, 32'h0);
    advance();

    // Reset when the clear counter has reached 10
    idle(); s_clr = 1'b1; step();
    for (int i = 0; i < 10; i++) begin idle(); step(); end
    idle(); s_rst = 1'b1; step();
    idle();
    wait_ready(n);
    chk("busy_len_midclr", n, 32);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      bit narrow;
      idle();
      narrow = ($urandom_range(0, 1) == 1);
      s_rst = ($urandom_range(0, 399) == 0);
      s_clr = ($urandom_range(0, 199) == 0);
      s_we0 = $urandom_range(0, 1);
      s_we1 = $urandom_range(0, 1);
      s_wa0 = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      s_wa1 = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      s_ra0 = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      s_ra1 = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      s_wd0 = $urandom();
      s_wd1 = $urandom();
      step();
    end

    idle();
    step();
    for (int k = 0; k < 10 && sb.size() > 0; k++) advance();
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
